// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Push-button debouncer with press, release and long-press
//                pulses plus a debounced pressed level.
//  Revision    : 1.0 - initial release
// ============================================================================

module key_debounce #(
    parameter int CNT_MAX  = 999_999,
    parameter int LONG_MAX = 49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_flag,
    output logic release_flag,
    output logic long_flag,
    output logic key_pressed
);

    localparam logic [24:0] C_CNT_MAX  = 25'(CNT_MAX);
    localparam logic [25:0] C_LONG_MAX = 26'(LONG_MAX);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_FILTER_DN = 2'd1;
    localparam logic [1:0] S_DOWN      = 2'd2;
    localparam logic [1:0] S_FILTER_UP = 2'd3;

    logic        key_s1_q;
    logic        key_s2_q;
    logic [1:0]  state_q,        state_d;
    logic [24:0] cnt_q,          cnt_d;
    logic [25:0] hold_cnt_q,     hold_cnt_d;
    logic        long_done_q,    long_done_d;
    logic        key_pressed_q,  key_pressed_d;
    logic        key_flag_q,     key_flag_d;
    logic        release_flag_q, release_flag_d;
    logic        long_flag_q,    long_flag_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
        end else begin
            key_s1_q <= key_in;
            key_s2_q <= key_s1_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hold_cnt_d     = hold_cnt_q;
        long_done_d    = long_done_q;
        key_pressed_d  = key_pressed_q;
        key_flag_d     = 1'b0;
        release_flag_d = 1'b0;
        long_flag_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d       = '0;
                hold_cnt_d  = '0;
                long_done_d = 1'b0;
                if (!key_s2_q) begin
                    state_d = S_FILTER_DN;
                end
            end

            S_FILTER_DN: begin
                if (key_s2_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d       = S_DOWN;
                    cnt_d         = '0;
                    key_pressed_d = 1'b1;
                    key_flag_d    = 1'b1;
                    hold_cnt_d    = '0;
                    long_done_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 25'd1;
                end
            end

            S_DOWN: begin
                // long_done_q keeps the saturated counter from re-firing long_flag
                if (key_s2_q) begin
                    state_d = S_FILTER_UP;
                    cnt_d   = '0;
                end else if (hold_cnt_q != C_LONG_MAX) begin
                    hold_cnt_d = hold_cnt_q + 26'd1;
                end else if (!long_done_q) begin
                    long_flag_d = 1'b1;
                    long_done_d = 1'b1;
                end
            end

            S_FILTER_UP: begin
                if (!key_s2_q) begin
                    state_d = S_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d        = S_IDLE;
                    cnt_d          = '0;
                    key_pressed_d  = 1'b0;
                    release_flag_d = 1'b1;
                    hold_cnt_d     = '0;
                    long_done_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 25'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            hold_cnt_q     <= '0;
            long_done_q    <= 1'b0;
            key_pressed_q  <= 1'b0;
            key_flag_q     <= 1'b0;
            release_flag_q <= 1'b0;
            long_flag_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            long_done_q    <= long_done_d;
            key_pressed_q  <= key_pressed_d;
            key_flag_q     <= key_flag_d;
            release_flag_q <= release_flag_d;
            long_flag_q    <= long_flag_d;
        end
    end

    assign key_flag     = key_flag_q;
    assign release_flag = release_flag_q;
    assign long_flag    = long_flag_q;
    assign key_pressed  = key_pressed_q;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce
//  Description : Directed self-checking bench for key_debounce (CNT_MAX=9,
//                LONG_MAX=49).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_key_debounce;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic key_in;
    logic key_flag;
    logic release_flag;
    logic long_flag;
    logic key_pressed;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int kf_cnt, rf_cnt, lf_cnt;
    int kf_at, rf_at, lf_at;
    int multi_cnt = 0;
    logic kp_at_kf;

    key_debounce #(
        .CNT_MAX  (9),
        .LONG_MAX (49)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_in       (key_in),
        .key_flag     (key_flag),
        .release_flag (release_flag),
        .long_flag    (long_flag),
        .key_pressed  (key_pressed)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic clear_obs();
        kf_cnt = 0; rf_cnt = 0; lf_cnt = 0;
        kf_at  = -1; rf_at = -1; lf_at = -1;
        kp_at_kf = 1'b0;
    endtask

    // Advances n rising edges, recording flag activity 1 time unit after each.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            cyc++;
            #1;
            if (key_flag === 1'b1)     begin kf_cnt++; kf_at = cyc; kp_at_kf = key_pressed; end
            if (release_flag === 1'b1) begin rf_cnt++; rf_at = cyc; end
            if (long_flag === 1'b1)    begin lf_cnt++; lf_at = cyc; end
            if (int'(key_flag === 1'b1) + int'(release_flag === 1'b1) + int'(long_flag === 1'b1) > 1)
                multi_cnt++;
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        key_in    = 1'b1;
        #23;
        total++; if (key_flag !== 1'b0)     begin bad++; $display("FAIL reset_key_flag: got %b expected 0", key_flag); end
        total++; if (release_flag !== 1'b0) begin bad++; $display("FAIL reset_release_flag: got %b expected 0", release_flag); end
        total++; if (long_flag !== 1'b0)    begin bad++; $display("FAIL reset_long_flag: got %b expected 0", long_flag); end
        total++; if (key_pressed !== 1'b0)  begin bad++; $display("FAIL reset_key_pressed: got %b expected 0", key_pressed); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_obs();
        run_cycles(5);
        total++; if (kf_cnt + rf_cnt + lf_cnt !== 0) begin bad++; $display("FAIL idle_no_flags: got %0d expected 0", kf_cnt + rf_cnt + lf_cnt); end
    endtask

    task automatic test_clean_press();
        int m;
        clear_obs();
        @(negedge sys_clk); key_in = 1'b0;
        run_cycles(1);
        m = cyc;
        run_cycles(20);
        total++; if (kf_cnt !== 1)     begin bad++; $display("FAIL press_count: got %0d expected 1", kf_cnt); end
        total++; if (kf_at - m !== 12) begin bad++; $display("FAIL press_latency: got %0d expected 12", kf_at - m); end
        total++; if (kp_at_kf !== 1'b1) begin bad++; $display("FAIL press_level_at_flag: got %b expected 1", kp_at_kf); end
        total++; if (rf_cnt !== 0)     begin bad++; $display("FAIL press_no_release: got %0d expected 0", rf_cnt); end
    endtask

    task automatic test_long_press();
        int m;
        run_cycles(100);
        total++; if (lf_cnt !== 1)          begin bad++; $display("FAIL long_count: got %0d expected 1", lf_cnt); end
        total++; if (lf_at - kf_at !== 50)  begin bad++; $display("FAIL long_latency: got %0d expected 50", lf_at - kf_at); end
        total++; if (kf_cnt !== 1)          begin bad++; $display("FAIL long_single_press: got %0d expected 1", kf_cnt); end
        @(negedge sys_clk); key_in = 1'b1;
        run_cycles(1);
        m = cyc;
        run_cycles(20);
        total++; if (rf_cnt !== 1)          begin bad++; $display("FAIL release_count: got %0d expected 1", rf_cnt); end
        total++; if (rf_at - m !== 12)      begin bad++; $display("FAIL release_latency: got %0d expected 12", rf_at - m); end
        total++; if (key_pressed !== 1'b0)  begin bad++; $display("FAIL release_level: got %b expected 0", key_pressed); end
        total++; if (lf_cnt !== 1)          begin bad++; $display("FAIL long_no_repeat: got %0d expected 1", lf_cnt); end
    endtask

    task automatic test_bounce();
        clear_obs();
        for (int r = 0; r < 5; r++) begin
            @(negedge sys_clk); key_in = 1'b0;
            run_cycles(8);
            @(negedge sys_clk); key_in = 1'b1;
            run_cycles(8);
        end
        run_cycles(10);
        total++; if (kf_cnt !== 0)          begin bad++; $display("FAIL bounce_no_press: got %0d expected 0", kf_cnt); end
        total++; if (key_pressed !== 1'b0)  begin bad++; $display("FAIL bounce_level: got %b expected 0", key_pressed); end
        total++; if (dut.state_q !== 2'd0)  begin bad++; $display("FAIL bounce_idle: got %0d expected 0", dut.state_q); end
    endtask

    task automatic test_release_bounce();
        int m;
        int f;
        clear_obs();
        @(negedge sys_clk); key_in = 1'b0;
        run_cycles(1);
        m = cyc;
        run_cycles(12);
        total++; if (kf_at - m !== 12) begin bad++; $display("FAIL rb_press_latency: got %0d expected 12", kf_at - m); end
        f = kf_at;
        run_cycles(10);
        @(negedge sys_clk); key_in = 1'b1;
        run_cycles(5);
        @(negedge sys_clk); key_in = 1'b0;
        run_cycles(60);
        // hold counter frozen for 6 cycles pushes long_flag from 50 to 56
        total++; if (rf_cnt !== 0)          begin bad++; $display("FAIL rb_no_release: got %0d expected 0", rf_cnt); end
        total++; if (key_pressed !== 1'b1)  begin bad++; $display("FAIL rb_level: got %b expected 1", key_pressed); end
        total++; if (lf_cnt !== 1)          begin bad++; $display("FAIL rb_long_count: got %0d expected 1", lf_cnt); end
        total++; if (lf_at - f !== 56)      begin bad++; $display("FAIL rb_long_latency: got %0d expected 56", lf_at - f); end
        @(negedge sys_clk); key_in = 1'b1;
        run_cycles(21);
        total++; if (rf_cnt !== 1)          begin bad++; $display("FAIL rb_final_release: got %0d expected 1", rf_cnt); end
    endtask

    task automatic test_reset_mid_filter();
        int m;
        clear_obs();
        @(negedge sys_clk); key_in = 1'b0;
        run_cycles(8);
        total++; if (dut.cnt_q !== 25'd5) begin bad++; $display("FAIL mf_cnt_before: got %0d expected 5", dut.cnt_q); end
        #2;
        sys_rst_n = 1'b0;
        #1;
        total++; if (dut.cnt_q !== 25'd0)   begin bad++; $display("FAIL mf_async_cnt: got %0d expected 0", dut.cnt_q); end
        total++; if (dut.state_q !== 2'd0)  begin bad++; $display("FAIL mf_async_state: got %0d expected 0", dut.state_q); end
        run_cycles(3);
        @(negedge sys_clk); sys_rst_n = 1'b1;
        run_cycles(1);
        m = cyc;
        run_cycles(20);
        total++; if (kf_cnt !== 1)     begin bad++; $display("FAIL mf_press_count: got %0d expected 1", kf_cnt); end
        total++; if (kf_at - m !== 12) begin bad++; $display("FAIL mf_press_latency: got %0d expected 12", kf_at - m); end
    endtask

    task automatic test_reset_mid_press();
        clear_obs();
        @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        #1;
        total++; if (key_pressed !== 1'b0)       begin bad++; $display("FAIL mp_async_level: got %b expected 0", key_pressed); end
        total++; if (dut.hold_cnt_q !== 26'd0)   begin bad++; $display("FAIL mp_async_hold: got %0d expected 0", dut.hold_cnt_q); end
        key_in = 1'b1;
        run_cycles(2);
        @(negedge sys_clk); sys_rst_n = 1'b1;
        run_cycles(25);
        total++; if (kf_cnt + rf_cnt + lf_cnt !== 0) begin bad++; $display("FAIL mp_no_flags: got %0d expected 0", kf_cnt + rf_cnt + lf_cnt); end
    endtask

    task automatic test_short_tap();
        int m;
        clear_obs();
        @(negedge sys_clk); key_in = 1'b0;
        run_cycles(1);
        m = cyc;
        run_cycles(12);
        total++; if (kf_at - m !== 12) begin bad++; $display("FAIL tap_press_latency: got %0d expected 12", kf_at - m); end
        @(negedge sys_clk); key_in = 1'b1;
        run_cycles(1);
        m = cyc;
        run_cycles(20);
        total++; if (rf_cnt !== 1)          begin bad++; $display("FAIL tap_release_count: got %0d expected 1", rf_cnt); end
        total++; if (rf_at - m !== 12)      begin bad++; $display("FAIL tap_release_latency: got %0d expected 12", rf_at - m); end
        total++; if (lf_cnt !== 0)          begin bad++; $display("FAIL tap_no_long: got %0d expected 0", lf_cnt); end
        total++; if (key_pressed !== 1'b0)  begin bad++; $display("FAIL tap_level: got %b expected 0", key_pressed); end
    endtask

    task automatic test_flag_exclusive();
        total++; if (multi_cnt !== 0) begin bad++; $display("FAIL flag_exclusive: got %0d overlapping cycles expected 0", multi_cnt); end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_clean_press();
        test_long_press();
        test_bounce();
        test_release_bounce();
        test_reset_mid_filter();
        test_reset_mid_press();
        test_short_tap();
        test_flag_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter CNT_MAX, default 999_999, meaning the debounce window minus one in clocks (20 ms at 50 MHz); legal range 1..2^25-1.
REQ-002 SHALL have parameter LONG_MAX, default 49_999_999, meaning the long-press threshold in clocks after the press is accepted (1 s at 50 MHz); legal range 1..2^26-1.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port key_in, input, 1 bit: raw asynchronous push-button, low = pressed.
REQ-006 SHALL have port key_flag, output, 1 bit: one-cycle pulse when a press is accepted.
REQ-007 SHALL have port release_flag, output, 1 bit: one-cycle pulse when a release is accepted.
REQ-008 SHALL have port long_flag, output, 1 bit: one-cycle pulse when a hold reaches LONG_MAX.
REQ-009 SHALL have port key_pressed, output, 1 bit: debounced level, 1 = pressed.

Function
REQ-010 SHALL pass key_in through a two-flop synchronizer (key_s1 -> key_s2, both reset to 1); FSM logic uses key_s2 only.
REQ-011 SHALL implement FSM states IDLE, FILTER_DN, DOWN and FILTER_UP, with a 25-bit debounce counter cnt and a 26-bit hold counter hold_cnt.
REQ-012 In IDLE, key_s2 = 0 SHALL move to FILTER_DN with cnt = 0; otherwise stay in IDLE.
REQ-013 In FILTER_DN, key_s2 = 1 SHALL return to IDLE with cnt = 0 (bounce rejected, no flag).
REQ-014 In FILTER_DN, key_s2 = 0 with cnt == CNT_MAX SHALL move to DOWN, set key_pressed = 1, pulse key_flag and load hold_cnt = 0; otherwise cnt increments by 1.
REQ-015 Press latency: key_flag SHALL rise CNT_MAX+3 edges after the edge at which key_s1 first captures a 0 that then stays low.
REQ-016 In DOWN, hold_cnt SHALL increment each cycle until it equals LONG_MAX; at that cycle long_flag pulses once, and hold_cnt then saturates with no further long_flag for that press.
REQ-017 In DOWN, key_s2 = 1 SHALL move to FILTER_UP with cnt = 0; hold_cnt keeps its value.
REQ-018 In FILTER_UP, key_s2 = 0 SHALL return to DOWN (release bounce rejected); hold_cnt resumes and key_pressed stays 1.
REQ-019 hold_cnt SHALL freeze while in FILTER_UP.
REQ-020 In FILTER_UP, key_s2 = 1 with cnt == CNT_MAX SHALL move to IDLE, clear key_pressed, pulse release_flag and clear hold_cnt; otherwise cnt increments.
REQ-021 All flags SHALL be registered outputs, high for exactly one cycle per event, never two flags in the same cycle.
REQ-022 cnt SHALL never exceed CNT_MAX and hold_cnt SHALL never exceed LONG_MAX; no wrap-around.
REQ-023 A key held indefinitely SHALL produce exactly one key_flag and at most one long_flag until release is accepted.

Reset
REQ-024 sys_rst_n low SHALL immediately set state = IDLE, cnt = 0, hold_cnt = 0, key_s1 = key_s2 = 1, key_pressed = 0, and key_flag = release_flag = long_flag = 0, regardless of clock.
REQ-025 Reset asserted mid-press or mid-filter SHALL abort the event: no flag pulses on or after deassertion until a full new debounce window completes.
REQ-026 After reset deassertion with key_in already low, the block SHALL treat it as a new press (full CNT_MAX+3 latency).

Verification (CNT_MAX = 9, LONG_MAX = 49)
REQ-027 Clean press: key_in 1 -> 0 and held -> key_flag pulses once, 12 edges after key_s1 captures 0; key_pressed = 1 from that cycle.
REQ-028 Bounce reject: key_in low for 8 clocks then high, repeated 5 times -> no key_flag, state returns to IDLE, key_pressed stays 0.
REQ-029 Long press: hold for 100 clocks after key_flag -> exactly one long_flag, 50 cycles after key_flag; release -> one release_flag, 12 edges after key_s1 captures 1.
REQ-030 Release bounce: while pressed, key_in high for 5 clocks then low -> no release_flag; key_pressed stays 1; hold_cnt resumes from its frozen value.
REQ-031 Reset mid-filter: assert sys_rst_n low when cnt = 5 in FILTER_DN -> all outputs 0 asynchronously; key held low through deassertion -> key_flag 12 edges after the first post-reset key_s1 capture.
REQ-032 Short tap: press for exactly the debounce window then release -> key_flag, then release_flag, with no long_flag.
